latch_loader: RTL and testbench

LATCH_LOADER -- requirements
Module: latch_loader

---
 rtl/latch_loader_pkg.sv | 14 +
 rtl/latch_loader_strobe_timer.sv | 34 +++
 rtl/latch_loader.sv | 134 +++++++++++++
 tb/tb_latch_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/latch_loader_pkg.sv
// Shared FSM state encoding and strobe counter width for latch_loader.
package latch_loader_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      WAIT   = 3'd4
   } state_t;

endpackage

// File: rtl/latch_loader_strobe_timer.sv
// Down-counter that times the latch-enable pulse; done is high at terminal count zero.
module strobe_timer
   import latch_loader_pkg::*;
#(
   parameter int STROBE_LEN = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic done
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STROBE_LEN - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = LOAD_VAL;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/latch_loader.sv
// Handshaked loader that captures a word and strobes a downstream D-latch bank.
// Optional macro LATCH_LOADER_PARITY_EN adds even-parity checking (par in, err out).
//
// state  | meaning
// IDLE   | rfd=1, waiting for dav_=0 to capture data
// SETUP  | one cycle of d stable with c=0 before the strobe
// STROBE | c=1 for STROBE_LEN cycles
// HOLD   | one cycle of d stable after c falls
// WAIT   | rfd=0 until the producer releases dav_
module latch_loader
   import latch_loader_pkg::*;
#(
   parameter int W          = 8,
   parameter int STROBE_LEN = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         dav_,
   input  logic [W-1:0] data,
`ifdef LATCH_LOADER_PARITY_EN
   input  logic         par,
   output logic         err,
`endif
   output logic         rfd,
   output logic [W-1:0] d,
   output logic         c
);

   state_t       state_q, state_d;
   logic         rfd_q, rfd_d;
   logic         c_q, c_d;
   logic [W-1:0] d_q, d_d;
   logic         load_tmr;
   logic         tmr_done;
   logic         par_ok;

`ifdef LATCH_LOADER_PARITY_EN
   logic err_q, err_d;

   assign par_ok = ~(^{data, par});
   // A rejected capture is the only source of err; it self-clears next cycle.
   assign err_d  = (state_q == IDLE) && !dav_ && !par_ok;

   always_ff @(posedge clock) begin
      if (reset)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
`else
   assign par_ok = 1'b1;
`endif

   strobe_timer #(.STROBE_LEN(STROBE_LEN)) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (load_tmr),
      .done  (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      rfd_d    = rfd_q;
      c_d      = c_q;
      d_d      = d_q;
      load_tmr = 1'b0;
      case (state_q)
         IDLE: begin
            rfd_d = 1'b1;
            c_d   = 1'b0;
            if (!dav_) begin
               rfd_d = 1'b0;
               if (par_ok) begin
                  d_d     = data;
                  state_d = SETUP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         SETUP: begin
            c_d      = 1'b1;
            load_tmr = 1'b1;
            state_d  = STROBE;
         end
         STROBE: begin
            if (tmr_done) begin
               c_d     = 1'b0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (dav_) begin
               rfd_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dav_) begin
               rfd_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            rfd_d   = 1'b1;
            c_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         rfd_q   <= 1'b1;
         c_q     <= 1'b0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         rfd_q   <= rfd_d;
         c_q     <= c_d;
         d_q     <= d_d;
      end
   end

   assign rfd = rfd_q;
   assign c   = c_q;
   assign d   = d_q;

endmodule

// File: tb/tb_latch_loader.sv
// Directed bench for latch_loader: one instance with STROBE_LEN=2, one with STROBE_LEN=1.
module tb_latch_loader;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       dav_a = 1'b1;
   logic [7:0] data_a = 8'h00;
   logic       rfd_a, c_a;
   logic [7:0] d_a;
   logic       dav_b = 1'b1;
   logic [7:0] data_b = 8'h00;
   logic       rfd_b, c_b;
   logic [7:0] d_b;

   int total = 0;
   int bad   = 0;

`ifdef LATCH_LOADER_PARITY_EN
   logic par_a, par_b, err_a, err_b;
   logic par_bad = 1'b0;
   assign par_a = (^data_a) ^ par_bad;
   assign par_b = ^data_b;
`endif

   always #5 clock = ~clock;

   latch_loader #(.W(8), .STROBE_LEN(2)) dut_a (
      .clock (clock),
      .reset (reset),
      .dav_  (dav_a),
      .data  (data_a),
`ifdef LATCH_LOADER_PARITY_EN
      .par   (par_a),
      .err   (err_a),
`endif
      .rfd   (rfd_a),
      .d     (d_a),
      .c     (c_a)
   );

   latch_loader #(.W(8), .STROBE_LEN(1)) dut_b (
      .clock (clock),
      .reset (reset),
      .dav_  (dav_b),
      .data  (data_b),
`ifdef LATCH_LOADER_PARITY_EN
      .par   (par_b),
      .err   (err_b),
`endif
      .rfd   (rfd_b),
      .d     (d_b),
      .c     (c_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int pulses;
      int highs;
      logic [7:0] words [3];
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h33;

      // reset for two cycles
      step();
      step();
      chk("rst_rfd", rfd_a, 1);
      chk("rst_c", c_a, 0);
      chk("rst_d", d_a, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_c", c_a, 0);
         chk("idle_rfd", rfd_a, 1);
      end

      // single capture of A5, data changes afterwards must be ignored
      data_a = 8'hA5;
      dav_a  = 1'b0;
      step();
      chk("cap_d", d_a, 8'hA5);
      chk("cap_c", c_a, 0);
      chk("cap_rfd", rfd_a, 0);
      dav_a  = 1'b1;
      data_a = 8'hFF;
      step();
      chk("k1_c", c_a, 1);
      chk("k1_d", d_a, 8'hA5);
      step();
      chk("k2_c", c_a, 1);
      step();
      chk("k3_c", c_a, 0);
      chk("k3_rfd", rfd_a, 0);
      chk("k3_d", d_a, 8'hA5);
      step();
      chk("k4_rfd", rfd_a, 1);
      chk("k4_d", d_a, 8'hA5);

      // dav_ held low for 10 cycles: one pulse only
      data_a = 8'h3C;
      dav_a  = 1'b0;
      pulses = 0;
      highs  = 0;
      for (int i = 0; i < 10; i++) begin
         logic c_prev;
         c_prev = c_a;
         step();
         chk("hold_rfd", rfd_a, 0);
         if (c_a && !c_prev) pulses++;
         if (c_a) highs++;
         data_a = data_a + 8'h01;
      end
      chk("hold_pulses", pulses, 1);
      chk("hold_highs", highs, 2);
      chk("hold_d", d_a, 8'h3C);
      dav_a = 1'b1;
      step();
      chk("rel_rfd", rfd_a, 1);
      step();
      chk("rel_c", c_a, 0);
      chk("rel_d", d_a, 8'h3C);

      // reset during the first STROBE cycle
      data_a = 8'h5A;
      dav_a  = 1'b0;
      step();
      dav_a = 1'b1;
      step();
      chk("pre_rst_c", c_a, 1);
      reset = 1'b1;
      step();
      chk("mid_rst_c", c_a, 0);
      chk("mid_rst_rfd", rfd_a, 1);
      chk("mid_rst_d", d_a, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_c", c_a, 0);
         chk("post_rst_d", d_a, 8'h00);
      end

      // STROBE_LEN=1, three words back to back
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         data_b = words[i];
         dav_b  = 1'b0;
         step();
         chk("b2b_pre_d", d_b, words[i]);
         chk("b2b_pre_c", c_b, 0);
         dav_b  = 1'b1;
         data_b = 8'hEE;
         step();
         chk("b2b_pulse_c", c_b, 1);
         chk("b2b_pulse_d", d_b, words[i]);
         if (c_b) pulses++;
         step();
         chk("b2b_post_c", c_b, 0);
         chk("b2b_post_d", d_b, words[i]);
         step();
         chk("b2b_rfd", rfd_b, 1);
         chk("b2b_idle_c", c_b, 0);
      end
      chk("b2b_pulses", pulses, 3);

`ifdef LATCH_LOADER_PARITY_EN
      // parity error on capture: err pulse, no strobe, d unchanged
      data_a  = 8'h01;
      par_bad = 1'b1;
      dav_a   = 1'b0;
      step();
      chk("par_err", err_a, 1);
      chk("par_c", c_a, 0);
      chk("par_d", d_a, 8'h00);
      chk("par_rfd", rfd_a, 0);
      dav_a   = 1'b1;
      par_bad = 1'b0;
      step();
      chk("par_err_clr", err_a, 0);
      chk("par_c2", c_a, 0);
      chk("par_rfd2", rfd_a, 1);
      step();
      chk("par_c3", c_a, 0);
      chk("par_d3", d_a, 8'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
